ex_alu_sequencer: RTL and testbench

- EX-stage controller that accepts one ALU operation per cycle from ID/EX, registers the result, and holds the CMP flags for branch resolution in the next cycle.
- Executes single-cycle ops (add/sub/cmp/mul/shift/logic/mov) directly.
- Sequences DIV and MOD through an iterative restoring divider, asserting a pipeline stall while the divider is busy.
- Sits between the ID/EX pipeline register and EX/MEM; hazard unit consumes stall_EX.

---
 rtl/ex_pkg.sv | 24 ++
 rtl/ex_alu_sequencer_if.sv | 25 ++
 rtl/ex_iter_divider.sv | 66 ++++++
 rtl/ex_alu_sequencer.sv | 117 +++++++++++
 tb/tb_ex_alu_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared constants for the EX-stage ALU sequencer: op-select bit indices, flag bits, FSM states.
package ex_pkg;

  localparam int unsigned ALU_ADD = 9;
  localparam int unsigned ALU_SUB = 10;
  localparam int unsigned ALU_CMP = 11;
  localparam int unsigned ALU_MUL = 12;
  localparam int unsigned ALU_DIV = 13;
  localparam int unsigned ALU_MOD = 14;
  localparam int unsigned ALU_LSL = 15;
  localparam int unsigned ALU_LSR = 16;
  localparam int unsigned ALU_ASR = 17;
  localparam int unsigned ALU_OR  = 18;
  localparam int unsigned ALU_AND = 19;
  localparam int unsigned ALU_NOT = 20;
  localparam int unsigned ALU_MOV = 21;

  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_POS  = 1;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] DIV_BUSY = 1'b1;

endpackage

// File: rtl/ex_alu_sequencer_if.sv
// ID/EX issue bundle and EX result bundle of the ALU sequencer.
interface ex_alu_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             issue_valid;
  logic [21:9]      ALU_Signals;
  logic [WIDTH-1:0] Operand_EX_A;
  logic [WIDTH-1:0] Operand_EX_B;
  logic             flush;
  logic             stall_EX;
  logic             result_valid;
  logic [WIDTH-1:0] EX_ALU_Result;
  logic [1:0]       flags;
  logic             div_by_zero;

  modport master (
    output issue_valid, ALU_Signals, Operand_EX_A, Operand_EX_B, flush,
    input  stall_EX, result_valid, EX_ALU_Result, flags, div_by_zero
  );

  modport slave (
    input  issue_valid, ALU_Signals, Operand_EX_A, Operand_EX_B, flush,
    output stall_EX, result_valid, EX_ALU_Result, flags, div_by_zero
  );
endinterface

// File: rtl/ex_iter_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; quotient/remainder are valid with done.
module ex_iter_divider #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV_STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int unsigned CntW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  logic             busy_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CntW'(DIV_STEPS - 1));
  assign quotient  = quo_d;
  assign remainder = rem_d;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ex_alu_sequencer.sv
// EX-stage controller: single-cycle ALU ops, iterative DIV/MOD with stall, CMP flag register.
module ex_alu_sequencer
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV_STEPS = WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  ex_alu_sequencer_if.slave bus
);
  logic [WIDTH-1:0] a, b, diff, alu_res, res_q, div_quo, div_rem;
  logic [12:0]      sig, sel;
  logic [0:0]       state_q, state_d;
  logic [1:0]       flags_q;
  logic stall, accept, is_div, is_mod, is_divmod, is_cmp, b_zero, shift_big;
  logic rv_q, dbz_q, op_div_q, div_start, div_busy, div_done;

  assign a   = bus.Operand_EX_A;
  assign b   = bus.Operand_EX_B;
  assign sig = bus.ALU_Signals;
  // Isolate the lowest set select bit so the lowest index wins.
  assign sel = sig & (~sig + 13'd1);

  assign is_div    = sel[ALU_DIV-ALU_ADD];
  assign is_mod    = sel[ALU_MOD-ALU_ADD];
  assign is_cmp    = sel[ALU_CMP-ALU_ADD];
  assign is_divmod = is_div | is_mod;
  assign b_zero    = (b == '0);

  assign stall     = (state_q == DIV_BUSY);
  assign accept    = bus.issue_valid && !stall && !bus.flush;
  assign div_start = accept && is_divmod && !b_zero;

  always_comb begin
    diff      = a - b;
    shift_big = (b >= WIDTH'(WIDTH));
    alu_res   = '0;
    unique case (1'b1)
      sel[ALU_ADD-ALU_ADD]: alu_res = a + b;
      sel[ALU_SUB-ALU_ADD]: alu_res = diff;
      sel[ALU_CMP-ALU_ADD]: alu_res = diff;
      sel[ALU_MUL-ALU_ADD]: alu_res = a * b;
      sel[ALU_LSL-ALU_ADD]: alu_res = shift_big ? '0 : (a << b);
      sel[ALU_LSR-ALU_ADD]: alu_res = shift_big ? '0 : (a >> b);
      sel[ALU_ASR-ALU_ADD]: alu_res = shift_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
      sel[ALU_OR-ALU_ADD]:  alu_res = a | b;
      sel[ALU_AND-ALU_ADD]: alu_res = a & b;
      sel[ALU_NOT-ALU_ADD]: alu_res = ~a;
      sel[ALU_MOV-ALU_ADD]: alu_res = b;
      default:              alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (div_start) state_d = DIV_BUSY;
      DIV_BUSY: if (bus.flush || div_done || !div_busy) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      res_q    <= '0;
      flags_q  <= '0;
      rv_q     <= 1'b0;
      dbz_q    <= 1'b0;
      op_div_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= 1'b0;
      dbz_q   <= 1'b0;
      if (accept && !is_divmod) begin
        res_q <= alu_res;
        rv_q  <= 1'b1;
        if (is_cmp) begin
          flags_q[FLAG_ZERO] <= (a == b);
          flags_q[FLAG_POS]  <= !diff[WIDTH-1] && (diff != '0);
        end
      end else if (accept && b_zero) begin
        // Divide by zero resolves immediately without entering the divider.
        res_q <= is_div ? '1 : a;
        rv_q  <= 1'b1;
        dbz_q <= 1'b1;
      end else if (div_start) begin
        op_div_q <= is_div;
      end else if (stall && div_done && !bus.flush) begin
        res_q <= op_div_q ? div_quo : div_rem;
        rv_q  <= 1'b1;
      end
    end
  end

  ex_iter_divider #(
    .WIDTH     (WIDTH),
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (bus.flush),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign bus.stall_EX      = stall;
  assign bus.result_valid  = rv_q;
  assign bus.EX_ALU_Result = res_q;
  assign bus.flags         = flags_q;
  assign bus.div_by_zero   = dbz_q;
endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Scoreboard bench: driver pushes model results with their due cycle, monitor pops on result_valid.
module tb_ex_alu_sequencer;
  localparam int DIV_LAT = 33;

  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic [1:0]  flags;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_end = -1;
  logic [1:0]  ref_flags = 2'b00;
  logic [31:0] last_res = '0;
  logic [1:0]  last_flags = 2'b00;
  exp_t sb[$];

  ex_alu_sequencer_if #(.WIDTH(32)) bus ();

  ex_alu_sequencer #(.WIDTH(32), .DIV_STEPS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: priority decode then plain arithmetic; lat is cycles from accept to result.
  task automatic ref_exec(input logic [12:0] sig, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic dz, output int lat);
    int k;
    k = -1;
    for (int i = 0; i < 13; i++) if (sig[i] && k < 0) k = i;
    r = '0;
    dz = 1'b0;
    lat = 1;
    case (k + 9)
      9:  r = a + b;
      10: r = a - b;
      11: begin
        r = a - b;
        ref_flags = {1'($signed(r) > 0), 1'(a == b)};
      end
      12: r = a * b;
      13: if (b == 0) begin r = '1; dz = 1'b1; end else begin r = a / b; lat = DIV_LAT; end
      14: if (b == 0) begin r = a; dz = 1'b1; end else begin r = a % b; lat = DIV_LAT; end
      15: r = (b >= 32) ? 32'd0 : a << b;
      16: r = (b >= 32) ? 32'd0 : a >> b;
      17: r = (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
      18: r = a | b;
      19: r = a & b;
      20: r = ~a;
      21: r = b;
      default: r = '0;
    endcase
  endtask

  task automatic step(input logic v, input logic [12:0] sig, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, output logic acc);
    logic model_stall;
    exp_t e;
    int lat;
    @(negedge clk);
    model_stall = (cyc <= busy_end);
    chk("stall_EX", 32'(bus.stall_EX), 32'(model_stall));
    bus.issue_valid  = v;
    bus.ALU_Signals  = sig;
    bus.Operand_EX_A = a;
    bus.Operand_EX_B = b;
    bus.flush        = fl;
    acc = v && !fl && !model_stall;
    if (fl && model_stall) begin
      void'(sb.pop_back());
      busy_end = cyc;
    end
    if (acc) begin
      ref_exec(sig, a, b, e.res, e.dbz, lat);
      e.flags = ref_flags;
      e.cyc = cyc + lat;
      if (lat > 1) busy_end = cyc + lat - 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 13'd0, '0, '0, 1'b0, acc);
  endtask

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    int n;
    n = 0;
    do begin
      step(1'b1, 13'(1) << (op - 9), a, b, 1'b0, acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("issue_timeout", 32'(n), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.issue_valid = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk);
    sb.delete();
    busy_end = -1;
    ref_flags = 2'b00;
    last_res = '0;
    last_flags = 2'b00;
    @(negedge clk);
    chk("rst_result_valid", 32'(bus.result_valid), 32'(0));
    chk("rst_result", bus.EX_ALU_Result, 32'(0));
    chk("rst_flags", 32'(bus.flags), 32'(0));
    chk("rst_dbz", 32'(bus.div_by_zero), 32'(0));
    chk("rst_stall", 32'(bus.stall_EX), 32'(0));
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.result_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_result_valid", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("result_cycle", 32'(cyc), 32'(e.cyc));
          chk("result", bus.EX_ALU_Result, e.res);
          chk("flags", 32'(bus.flags), 32'(e.flags));
          chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
          last_res = e.res;
          last_flags = e.flags;
        end
      end else begin
        chk("result_hold", bus.EX_ALU_Result, last_res);
        chk("flags_hold", 32'(bus.flags), 32'(last_flags));
        chk("dbz_idle", 32'(bus.div_by_zero), 32'(0));
      end
    end
  end

  initial begin
    logic acc;
    logic [12:0] sig;
    logic [31:0] a, b;
    int r, k;
    bus.issue_valid = 1'b0;
    bus.ALU_Signals = '0;
    bus.Operand_EX_A = '0;
    bus.Operand_EX_B = '0;
    bus.flush = 1'b0;
    do_reset();

    issue(9, 32'd7, 32'd5);
    issue(11, 32'd3, 32'd3);
    issue(11, 32'd2, 32'd5);
    issue(11, 32'h8000_0000, 32'd1);
    issue(13, 32'd100, 32'd7);
    issue(9, 32'd1, 32'd2);            // held through the stall
    issue(14, 32'd100, 32'd7);
    issue(13, 32'd9, 32'd0);
    issue(14, 32'd9, 32'd0);
    issue(17, 32'hF000_0000, 32'd40);
    issue(15, 32'd1, 32'd32);
    step(1'b1, 13'b0_0000_0000_1001, 32'd3, 32'd4, 1'b0, acc);
    step(1'b1, 13'd0, 32'd3, 32'd4, 1'b0, acc);
    idle(2);

    // Flush the divider after ten steps; then flush racing an issue; then flush after a result.
    issue(13, 32'hFFFF_FFFF, 32'd3);
    idle(10);
    step(1'b0, 13'd0, '0, '0, 1'b1, acc);
    idle(3);
    step(1'b1, 13'(1) << 0, 32'd5, 32'd5, 1'b1, acc);
    issue(10, 32'd1, 32'd9);
    step(1'b0, 13'd0, '0, '0, 1'b1, acc);
    idle(40);

    issue(13, 32'd1000, 32'd3);
    idle(20);
    do_reset();
    idle(40);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      k = int'($urandom_range(0, 12));
      if (r < 5) sig = '0;
      else if (r < 15) sig = 13'($urandom);
      else sig = 13'(1) << k;
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1, 2, 3: b = 32'($urandom_range(0, 40));
        default: b = $urandom;
      endcase
      do begin
        step(1'b1, sig, a, b, 1'b0, acc);
      end while (!acc && cyc < 90000);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    for (int i = 0; i < 60 && sb.size() != 0; i++) idle(1);
    idle(2);
    chk("drain", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
